// File: rtl/hv_parity_stream_decoder.sv
// Two-stage streaming decoder for the 24-bit row/column parity code around 16-bit data.
// Corrects any single-bit error, flags other non-zero syndromes, and keeps saturating error counts.
module hv_parity_stream_decoder #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [23:0]          in_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_data,
  output logic                 out_corrected,
  output logic                 out_uncorrectable,
  output logic [7:0]           out_syndrome,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] corr_cnt,
  output logic [CNT_WIDTH-1:0] uncorr_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Handshake: a word moves across an interface on a rising edge where valid && ready
  // are both high. Valid never depends on ready; in_ready is combinational from out_ready
  // so a full pipeline can still take a new word in the cycle its head word leaves.

  logic        s1_valid;
  logic [23:0] s1_code;

  logic        s2_valid;
  logic [15:0] s2_data;
  logic        s2_corr;
  logic        s2_unc;
  logic [7:0]  s2_syn;

  logic        s2_free;
  logic        s1_load;
  logic        s2_load;
  logic        out_xfer;

  assign s2_free  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid && s2_free;
  assign out_xfer = s2_valid && out_ready;

  logic [3:0]  row_syn;
  logic [3:0]  col_syn;
  logic [15:0] flip_mask;
  logic        data_err;
  logic        par_err;
  logic        syn_zero;
  logic [15:0] fix_data;
  logic        fix_corr;
  logic        fix_unc;

  always_comb begin
    row_syn   = '0;
    col_syn   = '0;
    flip_mask = '0;
    for (int r = 0; r < 4; r++) begin
      row_syn[r] = (^s1_code[4*r +: 4]) ^ s1_code[16+r];
    end
    for (int c = 0; c < 4; c++) begin
      col_syn[c] = s1_code[c] ^ s1_code[4+c] ^ s1_code[8+c] ^ s1_code[12+c] ^ s1_code[20+c];
    end
    // The only cell flagged by both a row and a column syndrome is the bad data bit.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        flip_mask[4*r+c] = row_syn[r] & col_syn[c];
      end
    end
    syn_zero = ({col_syn, row_syn} == 8'h00);
    data_err = $onehot(row_syn) && $onehot(col_syn);
    par_err  = $onehot({col_syn, row_syn});
    fix_corr = data_err || par_err;
    fix_unc  = !syn_zero && !fix_corr;
    fix_data = data_err ? (s1_code[15:0] ^ flip_mask) : s1_code[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_corr  <= 1'b0;
      s2_unc   <= 1'b0;
      s2_syn   <= '0;
    end else begin
      s1_valid <= s1_load || (s1_valid && !s2_load);
      s2_valid <= s2_load || (s2_valid && !out_ready);
      if (s1_load) begin
        s1_code <= in_code;
      end
      if (s2_load) begin
        s2_data <= fix_data;
        s2_corr <= fix_corr;
        s2_unc  <= fix_unc;
        s2_syn  <= {col_syn, row_syn};
      end
    end
  end

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else begin
      if (out_xfer && s2_corr && (corr_cnt != CNT_MAX)) begin
        corr_cnt <= corr_cnt + 1'b1;
      end
      if (out_xfer && s2_unc && (uncorr_cnt != CNT_MAX)) begin
        uncorr_cnt <= uncorr_cnt + 1'b1;
      end
    end
  end

  assign out_valid         = s2_valid;
  assign out_data          = s2_data;
  assign out_syndrome      = s2_syn;
  assign out_corrected     = s2_valid && s2_corr;
  assign out_uncorrectable = s2_valid && s2_unc;

endmodule
